gray_codec_pipe: RTL

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_codec_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipeline for Gray/binary conversion and Gray increment/decrement.
// S1 normalises the operand to binary. S2 forms the result and holds it under backpressure.
module gray_codec_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_wrap,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [1:0] MODE_B2G  = 2'b00;
  localparam logic [1:0] MODE_G2B  = 2'b01;
  localparam logic [1:0] MODE_GINC = 2'b10;
  localparam logic [1:0] MODE_GDEC = 2'b11;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_bin;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [1:0]       s2_mode;
  logic             s2_wrap;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] in_bin;
  logic [WIDTH-1:0] res_data;
  logic             res_wrap;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_mode  = s2_mode;
  assign out_wrap  = s2_wrap;

  assign in_bin = (in_mode == MODE_B2G) ? in_data : gray_to_bin(in_data);

  always_comb begin
    res_data = s1_bin;
    res_wrap = 1'b0;
    case (s1_mode)
      MODE_B2G:  res_data = bin_to_gray(s1_bin);
      MODE_G2B:  res_data = s1_bin;
      MODE_GINC: begin
        res_data = bin_to_gray(s1_bin + ONE);
        res_wrap = &s1_bin;
      end
      MODE_GDEC: begin
        res_data = bin_to_gray(s1_bin - ONE);
        res_wrap = ~|s1_bin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mode  <= '0;
      s2_wrap  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_bin  <= in_bin;
        end
      end
      // Output registers only change when a new word moves in; they hold while stalled.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res_data;
          s2_mode <= s1_mode;
          s2_wrap <= res_wrap;
        end
      end
      if (s2_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule
